dtw_sin_feeder: RTL and testbench
=================================

Name: dtw_sin_feeder

Overview:
- Upstream stage of the DTW top-level.
- Receives the reference sequence from the host pad interface one byte at a time and packs it into 32-bit little-endian sample words.
- Buffers the words in a first-word-fall-through (FWFT) FIFO and presents them on a valid/ready handshake that drives the top-level sample input (Sin_i/valid_i/ready_o).
- Tracks frame boundaries and reports overflow and end of frame.

Parameters:
- DEPTH, 16, FIFO depth in 32-bit words; must be a power of 2 and at least 2.
- FRAME_WORDS, 30, number of sample words in one reference frame.

Ports:
- clk_i  in  1  clock; all logic is on the rising edge.
- rst_i  in  1  synchronous reset, active-high.
- byte_i  in  8  host byte.
- byte_stb_i  in  1  byte_i is valid this cycle.
- sof_i  in  1  start of frame; only qualified when byte_stb_i=1.
- byte_par_i  in  1  even-parity bit for byte_i; used only when the macro is defined.
- clr_i  in  1  clears the sticky flags.
- Sin_o  out  32  FIFO head word.
- valid_o  out  1  FIFO not empty.
- ready_i  in  1  consumer accepts the head word.
- level_o  out  $clog2(DEPTH)+1  FIFO occupancy.
- ovf_o  out  1  sticky overflow flag.
- frame_done_o  out  1  one-cycle pulse at the end of a frame.
- par_err_o  out  1  sticky parity error flag.

Behaviour:
- Reset: rst_i=1 at a rising edge clears FIFO pointers, level_o, the packer lane counter, the packer holding register, the push and pop frame counters, ovf_o, par_err_o and frame_done_o.
  - Sin_o=0 and valid_o=0 in the cycle after reset.
  - Reset mid-word or mid-frame discards all partial state.
- Packer:
  - A 2-bit lane counter is 0 after reset.
  - Each accepted byte (byte_stb_i=1) goes to lane L, bits [8L+7:8L], and the counter increments modulo 4.
  - On lane 3 the word {byte_i, hold[23:0]} is pushed to the FIFO at the same edge. The packer adds no extra register.
- Start of frame: sof_i=1 with byte_stb_i=1 at the same edge
  - discards any partial word,
  - places byte_i in lane 0 and sets the lane counter to 1,
  - resets the push frame counter to 0.
- Push frame counter:
  - Counts successful pushes, saturating at FRAME_WORDS.
  - Once it reaches FRAME_WORDS, further bytes are ignored until the next sof_i.
  - After reset the block behaves as if a frame has just started.
- FIFO:
  - FWFT: valid_o = (level_o != 0) and Sin_o = mem[rd_ptr].
  - A pop occurs when valid_o and ready_i are both 1.
  - Pointers have log2(DEPTH) bits and wrap naturally.
  - Push while full without a pop in the same cycle: the word is dropped, ovf_o is set, and the push frame counter does not advance.
  - Push while full with a pop in the same cycle: the push is accepted and level_o stays at DEPTH.
  - Push while empty: valid_o rises in the next cycle and Sin_o equals the pushed word.
  - Simultaneous push and pop at any level: level_o is unchanged.
- Latency: the 4th byte strobed in cycle t gives valid_o=1 in cycle t+1 (FIFO previously empty).
- Pop frame counter:
  - Counts pops and wraps to 0 after FRAME_WORDS pops.
  - frame_done_o=1 in the cycle after the pop that brings the count to FRAME_WORDS.
  - The pop counter is not reset by sof_i.
- Sticky flags: ovf_o and par_err_o clear on clr_i=1. If a set event and clr_i occur at the same edge, the set wins.
- Ready behaviour: ready_i may toggle freely. Sin_o stays stable while valid_o=1 and ready_i=0.

Optional Feature:
- Macro: DTW_FEED_PARITY_EN.
- Defined:
  - Each accepted byte is checked: ^{byte_i, byte_par_i} must equal 0.
  - A failing byte marks the current word bad. When that word completes it is not pushed and the push frame counter does not advance.
  - par_err_o is set at the edge where the bad byte is accepted.
  - sof_i clears the bad mark.
- Undefined:
  - byte_par_i is ignored, par_err_o is tied to 0, and no parity logic is synthesized.

Test Plan:
- Pack and latency:
  - Stimulus: reset, then bytes 0x11, 0x22, 0x33, 0x44 on consecutive cycles with ready_i=0.
  - Response: one cycle after 0x44, valid_o=1, Sin_o=0x44332211 and level_o=1. It then holds stable while ready_i=0.
- Overflow (DEPTH=16, ready_i=0):
  - Stimulus: push 17 words 0x00000000 to 0x10101010.
  - Response: level_o=16 and ovf_o=1. Draining returns words 0 to 15; the 17th word is absent. clr_i then gives ovf_o=0.
- Full with simultaneous pop:
  - Stimulus: FIFO full; assert ready_i in the same cycle as a 4th byte.
  - Response: level_o stays 16, ovf_o stays 0, and the new word appears last in drain order.
- SOF realignment:
  - Stimulus: bytes 0xAA and 0xBB, then byte 0x01 with sof_i=1, then 0x02, 0x03, 0x04.
  - Response: exactly one word, Sin_o=0x04030201.
- Frame end:
  - Stimulus: FRAME_WORDS=30, 30 words pushed with ready_i=1 continuously; then 4 more bytes without sof_i.
  - Response: frame_done_o pulses once, in the cycle after the 30th pop. The extra 4 bytes produce no push and valid_o stays 0.
- Parity (macro defined):
  - Stimulus: the second byte of a word carries a bad parity bit.
  - Response: that word is never pushed, par_err_o=1 from the next cycle, and the following good word is pushed normally.

Source files
------------

// File: rtl/dtw_sin_feeder.sv
// dtw_sin_feeder: packs host bytes into 32-bit words behind an FWFT FIFO (parity check under DTW_FEED_PARITY_EN)
module dtw_sin_feeder #(
  parameter int DEPTH = 16,
  parameter int FRAME_WORDS = 30
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic [7:0]               byte_i,
  input  logic                     byte_stb_i,
  input  logic                     sof_i,
  input  logic                     byte_par_i,
  input  logic                     clr_i,
  output logic [31:0]              Sin_o,
  output logic                     valid_o,
  input  logic                     ready_i,
  output logic [$clog2(DEPTH):0]   level_o,
  output logic                     ovf_o,
  output logic                     frame_done_o,
  output logic                     par_err_o
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam int CW = $clog2(FRAME_WORDS + 1);
  logic [31:0]   mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [1:0]    lane;
  logic [23:0]   hold;
  logic [CW-1:0] push_cnt, pop_cnt;
  logic          bad, pbad, acc, want_push, full, pop, push_ok;
  assign valid_o   = level_o != '0;
  assign Sin_o     = valid_o ? mem[rd_ptr] : '0;
  assign full      = level_o == LW'(DEPTH);
  assign pop       = valid_o & ready_i;
  assign acc       = byte_stb_i & (sof_i | (push_cnt != CW'(FRAME_WORDS)));
  assign want_push = acc & ~sof_i & (lane == 2'd3) & ~bad & ~pbad;
  assign push_ok   = want_push & (~full | pop);
`ifdef DTW_FEED_PARITY_EN
  assign pbad = ^{byte_i, byte_par_i};
  // bad-word mark and sticky parity flag; a new word or sof starts clean
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      bad       <= 1'b0;
      par_err_o <= 1'b0;
    end else begin
      bad       <= acc ? (sof_i ? pbad : (lane == 2'd3) ? 1'b0 : bad | pbad) : bad;
      par_err_o <= (acc & pbad) | (par_err_o & ~clr_i);
    end
  end
`else
  logic unused_par;
  assign unused_par = byte_par_i;
  assign pbad       = 1'b0;
  assign bad        = 1'b0;
  assign par_err_o  = 1'b0;
`endif
  // packer, frame counters, FIFO pointers and sticky overflow
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      lane         <= '0;
      hold         <= '0;
      push_cnt     <= '0;
      pop_cnt      <= '0;
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      level_o      <= '0;
      ovf_o        <= 1'b0;
      frame_done_o <= 1'b0;
    end else begin
      if (acc) begin
        lane <= sof_i ? 2'd1 : lane + 2'd1;
        hold <= sof_i ? {16'h0, byte_i} :
                (lane == 2'd0) ? {hold[23:8], byte_i} :
                (lane == 2'd1) ? {hold[23:16], byte_i, hold[7:0]} :
                (lane == 2'd2) ? {byte_i, hold[15:0]} : hold;
      end
      push_cnt     <= (acc & sof_i) ? '0 : push_cnt + CW'(push_ok);
      wr_ptr       <= wr_ptr + AW'(push_ok);
      rd_ptr       <= rd_ptr + AW'(pop);
      level_o      <= level_o + LW'(push_ok) - LW'(pop);
      ovf_o        <= (want_push & full & ~pop) | (ovf_o & ~clr_i);
      pop_cnt      <= pop ? ((pop_cnt == CW'(FRAME_WORDS - 1)) ? '0 : pop_cnt + 1'b1) : pop_cnt;
      frame_done_o <= pop & (pop_cnt == CW'(FRAME_WORDS - 1));
    end
  end
  // FIFO storage, written with the completed word on lane 3
  always_ff @(posedge clk_i) begin
    if (push_ok) mem[wr_ptr] <= {byte_i, hold};
  end
endmodule

// File: tb/tb_dtw_sin_feeder.sv
// tb_dtw_sin_feeder: directed scoreboard bench for dtw_sin_feeder
module tb_dtw_sin_feeder;
  logic        clk_i = 0, rst_i = 1, byte_stb_i = 0, sof_i = 0, byte_par_i = 0, clr_i = 0, ready_i = 0;
  logic [7:0]  byte_i = 0;
  logic [31:0] Sin_o;
  logic        valid_o, ovf_o, frame_done_o, par_err_o;
  logic [4:0]  level_o;
  int          checks = 0, errors = 0, pc = 0, fd_cnt = 0;
  logic        started = 0, fd_exp = 0, bad_par = 0;
  logic [31:0] q[$];
  logic [31:0] exp_w;

  dtw_sin_feeder dut (
    .clk_i(clk_i), .rst_i(rst_i), .byte_i(byte_i), .byte_stb_i(byte_stb_i), .sof_i(sof_i),
    .byte_par_i(byte_par_i), .clr_i(clr_i), .Sin_o(Sin_o), .valid_o(valid_o), .ready_i(ready_i),
    .level_o(level_o), .ovf_o(ovf_o), .frame_done_o(frame_done_o), .par_err_o(par_err_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk_i);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic s = 1'b0);
    byte_i = b; byte_stb_i = 1; sof_i = s; byte_par_i = (^b) ^ bad_par;
    cyc();
    byte_stb_i = 0; sof_i = 0; bad_par = 0;
  endtask

  task automatic send_word(input logic [31:0] w, input logic expect_push);
    for (int i = 0; i < 4; i++) begin
      if (i == 3 && expect_push) q.push_back(w);
      send_byte(w[8*i +: 8]);
    end
  endtask

  task automatic drain();
    ready_i = 1;
    for (int i = 0; i < 40 && valid_o; i++) cyc();
    ready_i = 0;
    chk("drain_queue_empty", q.size(), 0);
    chk("drain_level", 32'(level_o), 0);
  endtask

  task automatic do_reset();
    rst_i = 1;
    cyc();
    rst_i = 0;
    q.delete();
    fd_cnt = 0;
  endtask

  // pop scoreboard and cycle-accurate frame_done model
  always @(negedge clk_i) if (started) begin
    if (rst_i) begin
      pc = 0;
      fd_exp = 0;
    end else begin
      chk("frame_done", 32'(frame_done_o), 32'(fd_exp));
      if (frame_done_o) fd_cnt++;
      fd_exp = 0;
      if (valid_o && ready_i) begin
        exp_w = q.size() != 0 ? q.pop_front() : 32'hxxxxxxxx;
        chk("pop_word", Sin_o, exp_w);
        pc++;
        if (pc == 30) begin
          fd_exp = 1;
          pc = 0;
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    cyc();
    started = 1;
    cyc();
    rst_i = 0;
    chk("rst_valid", 32'(valid_o), 0);
    chk("rst_sin", Sin_o, 0);
    chk("rst_level", 32'(level_o), 0);
    chk("rst_ovf", 32'(ovf_o), 0);
    chk("rst_par_err", 32'(par_err_o), 0);
    // pack and latency
    send_byte(8'h11); send_byte(8'h22); send_byte(8'h33);
    chk("pre_valid", 32'(valid_o), 0);
    q.push_back(32'h44332211);
    send_byte(8'h44);
    chk("pack_valid", 32'(valid_o), 1);
    chk("pack_sin", Sin_o, 32'h44332211);
    chk("pack_level", 32'(level_o), 1);
    cyc(); chk("hold_sin", Sin_o, 32'h44332211);
    cyc(); chk("hold_valid", 32'(valid_o), 1);
    drain();
    // overflow
    do_reset();
    for (int i = 0; i < 17; i++) send_word(32'h01010101 * i, i < 16);
    chk("ovf_level", 32'(level_o), 16);
    chk("ovf_flag", 32'(ovf_o), 1);
    drain();
    chk("ovf_sticky", 32'(ovf_o), 1);
    clr_i = 1; cyc(); clr_i = 0;
    chk("ovf_clr", 32'(ovf_o), 0);
    // full with simultaneous pop
    do_reset();
    for (int i = 0; i < 16; i++) send_word(32'hA0000000 + i, 1);
    chk("full_level", 32'(level_o), 16);
    send_byte(8'hEF); send_byte(8'hBE); send_byte(8'hAD);
    q.push_back(32'hDEADBEEF);
    ready_i = 1;
    send_byte(8'hDE);
    ready_i = 0;
    chk("fullpop_level", 32'(level_o), 16);
    chk("fullpop_ovf", 32'(ovf_o), 0);
    drain();
    // sof realignment
    do_reset();
    send_byte(8'hAA); send_byte(8'hBB);
    send_byte(8'h01, 1'b1); send_byte(8'h02); send_byte(8'h03);
    q.push_back(32'h04030201);
    send_byte(8'h04);
    chk("sof_level", 32'(level_o), 1);
    chk("sof_sin", Sin_o, 32'h04030201);
    drain();
    // frame end
    do_reset();
    ready_i = 1;
    for (int i = 0; i < 30; i++) send_word(32'h5A000000 + 32'(i * 3), 1);
    repeat (4) cyc();
    send_word(32'hCAFEF00D, 0);
    repeat (3) cyc();
    chk("frame_valid", 32'(valid_o), 0);
    chk("frame_level", 32'(level_o), 0);
    chk("frame_queue", q.size(), 0);
    chk("frame_done_once", fd_cnt, 1);
    ready_i = 0;
`ifdef DTW_FEED_PARITY_EN
    do_reset();
    send_byte(8'h01);
    bad_par = 1;
    send_byte(8'h02);
    chk("par_err_set", 32'(par_err_o), 1);
    send_byte(8'h03); send_byte(8'h04);
    chk("par_no_push", 32'(level_o), 0);
    send_word(32'h08070605, 1);
    chk("par_good_level", 32'(level_o), 1);
    chk("par_good_sin", Sin_o, 32'h08070605);
    drain();
    clr_i = 1; cyc(); clr_i = 0;
    chk("par_clr", 32'(par_err_o), 0);
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
